ssd_capture: RTL and testbench

//  Receive side of the seven-segment interface: watches a multiplexed display bus (active-low
//  one-hot anodes plus shared active-low segments {a,b,c,d,e,f,g} = seg[6:0]) and recovers the

---
 rtl/ssd_pkg.sv | 15 +
 rtl/ssd_decode.sv | 24 ++
 rtl/ssd_capture.sv | 150 +++++++++++++++
 tb/tb_ssd_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: the blank pattern and the active-low hex glyph table
// used by both the display encoder and the capture monitor.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}; entry n is the glyph for hex digit n (F listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage

// File: rtl/ssd_decode.sv
// Combinational segment decoder: active-low glyph -> hex nibble, with flags for a
// recognised hex glyph and for the all-off (blank) pattern.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// Seven-segment bus monitor: filters scan transitions, decodes each digit's glyph,
// flags illegal glyphs or anode words, and reports when a full frame has been seen.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_done,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic                    pattern_err,
  output logic                    anode_err
);

  localparam int SMP_W = NUM_DIGITS + 7;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDX_W:0]   ONE_Z   = 1;

  logic [SMP_W-1:0]    smp_p0;
  logic [CNT_W-1:0]    cnt_p0;
  logic                vld_p1;
  logic                same;

  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            seg_p1;
  logic                  dec_legal, dec_blank;
  logic [3:0]            dec_nib;
  logic [IDX_W:0]        zcnt;
  logic [IDX_W-1:0]      idx;

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_n;
  logic [NUM_DIGITS-1:0]      mask_q, mask_n, valid_n, blank_n;
  logic [4*NUM_DIGITS-1:0]    fval_n;
  logic                       fd_n, perr_n, aerr_n;

  // ---- stage 0: sample the bus and measure how long it has been stable ----
  assign same = ({an_in, seg_in} == smp_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_p0 <= {{NUM_DIGITS{1'b1}}, SEG_BLANK};
      cnt_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      smp_p0 <= {an_in, seg_in};
      vld_p1 <= same && (cnt_p0 == CNT_ACC);
      if (!same)
        cnt_p0 <= CNT_W'(1);
      else if (cnt_p0 != CNT_SAT)
        cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // ---- stage 1: act on the accepted sample, which is still held in smp_p0 ----
  assign an_p1  = smp_p0[SMP_W-1:7];
  assign seg_p1 = smp_p0[6:0];

  ssd_decode u_decode (
    .seg    (seg_p1),
    .legal  (dec_legal),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  always_comb begin
    zcnt = '0;
    idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_p1[i]) begin
        zcnt = zcnt + 1'b1;
        idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    dig_n   = dig_q;
    valid_n = digit_valid;
    blank_n = blank_out;
    mask_n  = mask_q;
    fval_n  = frame_value;
    fd_n    = 1'b0;
    perr_n  = 1'b0;
    aerr_n  = 1'b0;
    if (vld_p1) begin
      if (zcnt > ONE_Z) begin
        aerr_n = 1'b1;
      end else if (zcnt == ONE_Z) begin
        if (dec_legal) begin
          dig_n[idx]   = dec_nib;
          valid_n[idx] = 1'b1;
          blank_n[idx] = 1'b0;
          mask_n[idx]  = 1'b1;
        end else if (dec_blank) begin
          dig_n[idx]   = 4'h0;
          valid_n[idx] = 1'b1;
          blank_n[idx] = 1'b1;
          mask_n[idx]  = 1'b1;
        end else begin
          perr_n       = 1'b1;
          valid_n[idx] = 1'b0;
          blank_n[idx] = 1'b0;
          mask_n[idx]  = 1'b0;
        end
      end
      // A frame closes on the accept that completes the mask; snapshot includes that digit.
      if (&mask_n) begin
        fd_n   = 1'b1;
        fval_n = dig_n;
        mask_n = '0;
      end
    end
  end

  // ---- stage 2: registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q       <= '0;
      digit_valid <= '0;
      blank_out   <= '0;
      mask_q      <= '0;
      frame_value <= '0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      dig_q       <= dig_n;
      digit_valid <= valid_n;
      blank_out   <= blank_n;
      mask_q      <= mask_n;
      frame_value <= fval_n;
      frame_done  <= fd_n;
      pattern_err <= perr_n;
      anode_err   <= aerr_n;
    end
  end

  assign digits_out = dig_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: each directed scan step queues its hand-computed
// expected output event; a negedge monitor pops and compares on every observable change.
module tb_ssd_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic [3:0]  blank_out;
  logic        frame_done;
  logic [15:0] frame_value;
  logic        pattern_err;
  logic        anode_err;

  always #5 clk = ~clk;

  ssd_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .blank_out   (blank_out),
    .frame_done  (frame_done),
    .frame_value (frame_value),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  vld;
    logic [3:0]  blk;
    logic        fd;
    logic [15:0] fval;
    logic        perr;
    logic        aerr;
  } ev_t;

  ev_t         exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [39:0] prev_st = '0;
  logic [39:0] cur_st;
  ev_t         act_ev, exp_ev;

  task automatic push_ev(input logic [15:0] dig, input logic [3:0] vld, input logic [3:0] blk,
                         input logic fd, input logic [15:0] fval, input logic perr,
                         input logic aerr);
    ev_t e;
    e.dig = dig; e.vld = vld; e.blk = blk; e.fd = fd;
    e.fval = fval; e.perr = perr; e.aerr = aerr;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [3:0] an, input logic [6:0] seg);
    hold(an, seg, 6);
    hold(4'hF, 7'h7F, 2);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({digits_out, digit_valid, blank_out, frame_done, frame_value,
                pattern_err, anode_err});
  endfunction

  // Monitor: any pulse or any change of persistent outputs is one event.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_st = {digits_out, digit_valid, blank_out, frame_value};
      if (frame_done || pattern_err || anode_err || (cur_st != prev_st)) begin
        act_ev = {digits_out, digit_valid, blank_out, frame_done, frame_value,
                  pattern_err, anode_err};
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got dig=%h vld=%b blk=%b fd=%b fval=%h perr=%b aerr=%b, required no event",
                   act_ev.dig, act_ev.vld, act_ev.blk, act_ev.fd, act_ev.fval, act_ev.perr, act_ev.aerr);
        end else begin
          exp_ev = exp_q.pop_front();
          if (act_ev !== exp_ev) begin
            n_fail++;
            $display("FAIL event: got dig=%h vld=%b blk=%b fd=%b fval=%h perr=%b aerr=%b, required dig=%h vld=%b blk=%b fd=%b fval=%h perr=%b aerr=%b",
                     act_ev.dig, act_ev.vld, act_ev.blk, act_ev.fd, act_ev.fval, act_ev.perr, act_ev.aerr,
                     exp_ev.dig, exp_ev.vld, exp_ev.blk, exp_ev.fd, exp_ev.fval, exp_ev.perr, exp_ev.aerr);
          end
        end
      end
      prev_st = cur_st;
    end
  end

  initial begin
    // Reset held with a legal digit on the bus: outputs stay zero.
    reset  = 1'b1;
    an_in  = 4'b1110;
    seg_in = 7'b0000001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", all_outs(), 64'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_outputs", all_outs(), 64'h0);
    mon_en = 1'b1;
    hold(4'hF, 7'h7F, 2);

    // Digit 0 = 2 after exactly STABLE_CYCLES samples, visible one edge later.
    push_ev(16'h0002, 4'b0001, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    hold(4'b1110, 7'b0010010, 4);
    check("latency_early", 64'(digit_valid), 64'h0);
    @(posedge clk); #1;
    check("latency_digits", 64'({digits_out, digit_valid}), 64'h0002_1);
    hold(4'hF, 7'h7F, 2);
    hold(4'b1110, 7'b0000110, 3);
    hold(4'hF, 7'h7F, 6);
    check("short_run_ignored", 64'(digits_out), 64'h0002);

    // Full scan 1,2,3,4 -> a single frame.
    push_ev(16'h0001, 4'b0001, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b1110, 7'b1001111);
    push_ev(16'h0021, 4'b0011, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b1101, 7'b0010010);
    push_ev(16'h0321, 4'b0111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b1011, 7'b0000110);
    push_ev(16'h4321, 4'b1111, 4'b0000, 1'b1, 16'h4321, 1'b0, 1'b0);
    commit(4'b0111, 7'b1001100);

    // Illegal glyph on digit 2.
    push_ev(16'h4321, 4'b1011, 4'b0000, 1'b0, 16'h4321, 1'b1, 1'b0);
    commit(4'b1011, 7'b1111110);

    // Two anodes low, a long gap, then a blank digit 1.
    push_ev(16'h4321, 4'b1011, 4'b0000, 1'b0, 16'h4321, 1'b0, 1'b1);
    commit(4'b1100, 7'b0000001);
    hold(4'hF, 7'h7F, 8);
    push_ev(16'h4301, 4'b1011, 4'b0010, 1'b0, 16'h4321, 1'b0, 1'b0);
    commit(4'b1101, 7'b1111111);

    // Digits 0,1 then reset: the partial frame must be dropped.
    push_ev(16'h4305, 4'b1011, 4'b0010, 1'b0, 16'h4321, 1'b0, 1'b0);
    commit(4'b1110, 7'b0100100);
    push_ev(16'h4365, 4'b1011, 4'b0000, 1'b0, 16'h4321, 1'b0, 1'b0);
    commit(4'b1101, 7'b0100000);
    push_ev(16'h0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    hold(4'hF, 7'h7F, 2);
    reset = 1'b0;
    push_ev(16'h0700, 4'b0100, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b1011, 7'b0001111);
    push_ev(16'h8700, 4'b1100, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b0111, 7'b0000000);
    push_ev(16'h8709, 4'b1101, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    commit(4'b1110, 7'b0000100);
    push_ev(16'h87A9, 4'b1111, 4'b0000, 1'b1, 16'h87A9, 1'b0, 1'b0);
    commit(4'b1101, 7'b0001000);

    // Mask restarts empty after a frame; covers the remaining glyphs.
    push_ev(16'h8BA9, 4'b1111, 4'b0000, 1'b0, 16'h87A9, 1'b0, 1'b0);
    commit(4'b1011, 7'b1100000);
    push_ev(16'hCBA9, 4'b1111, 4'b0000, 1'b0, 16'h87A9, 1'b0, 1'b0);
    commit(4'b0111, 7'b0110001);
    push_ev(16'hCBAD, 4'b1111, 4'b0000, 1'b0, 16'h87A9, 1'b0, 1'b0);
    commit(4'b1110, 7'b1000010);
    push_ev(16'hCBED, 4'b1111, 4'b0000, 1'b1, 16'hCBED, 1'b0, 1'b0);
    commit(4'b1101, 7'b0110000);
    push_ev(16'hCBEF, 4'b1111, 4'b0000, 1'b0, 16'hCBED, 1'b0, 1'b0);
    commit(4'b1110, 7'b0111000);
    push_ev(16'hC0EF, 4'b1111, 4'b0000, 1'b0, 16'hCBED, 1'b0, 1'b0);
    commit(4'b1011, 7'b0000001);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    hold(4'hF, 7'h7F, 10);
    check("pending_events", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
